// File: rtl/ram1_pkg.sv
// Shared constants for the ram1 scratch RAM: default geometry and reset value.
package ram1_pkg;

  // Default word width in bits.
  localparam int unsigned DATA_W_DEF  = 32'd8;
  // Default address width in bits.
  localparam int unsigned ADDR_W_DEF  = 32'd8;
  // Number of words for the default geometry.
  localparam int unsigned DEPTH_DEF   = 32'd1 << ADDR_W_DEF;
  // Value loaded into every word and into the read register on reset.
  localparam int unsigned RST_VAL_DEF = 32'd0;

endpackage

// File: rtl/ram1.sv
// ram1: single-port synchronous RAM used as LBIST scratch storage.
// One shared address bus; wr picks write (1) or read (0) on each rising edge.
// Reads are registered (one cycle latency). Writes leave data_out untouched.
// Asynchronous reset clears the whole array and the read register.
module ram1
  import ram1_pkg::*;
#(
  parameter int unsigned          DATA_W  = DATA_W_DEF,
  parameter int unsigned          ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0]    RST_VAL = DATA_W'(RST_VAL_DEF)
) (
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              clk,
  input  logic              rst
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] data_out_q;

  // Array write / registered read; reset clears every word and the read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= RST_VAL;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= RST_VAL;
      end
    end else begin
      // An unknown wr matches neither arm, so nothing is written and data_out holds.
      case (wr)
        1'b1:    mem_q[addr] <= data_in;
        1'b0:    data_out_q  <= mem_q[addr];
        default: data_out_q  <= data_out_q;
      endcase
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_ram1.sv
// Self-checking bench for ram1. Stimulus drives inputs on the falling edge and
// pushes expected read data into a scoreboard queue; a monitor latches which
// rising edges carry a checked operation and compares data_out on the
// following falling edge.
module tb_ram1;

  logic [7:0] data_out;
  logic [7:0] data_in;
  logic [7:0] addr;
  logic       wr;
  logic       clk;
  logic       rst;

  typedef struct {
    logic [7:0] exp;
    logic [7:0] a;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_checks;
  int       n_pass;
  logic     issue_flag;

  ram1 dut (
    .data_out (data_out),
    .data_in  (data_in),
    .addr     (addr),
    .wr       (wr),
    .clk      (clk),
    .rst      (rst)
  );

  // 10 ns high / 10 ns low clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [7:0] a, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s addr=0x%02h: got 0x%02h, expected 0x%02h", name, a, act, exp);
    end
  endtask

  // Monitor: an edge issued with issue_flag set produces a value to compare.
  initial begin
    logic     fire;
    sb_item_t it;
    forever begin
      @(posedge clk);
      fire = issue_flag && !rst;
      @(negedge clk);
      if (fire) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty: got no expected entry, expected one");
        end else begin
          it = sb_q.pop_front();
          check("data_out", it.a, data_out, it.exp);
        end
      end
    end
  end

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr       = a;
    data_in    = d;
    wr         = 1'b1;
    issue_flag = 1'b0;
  endtask

  // Write while expecting data_out to keep the value 'hold'.
  task automatic do_write_hold(input logic [7:0] a, input logic [7:0] d, input logic [7:0] hold);
    @(negedge clk);
    addr       = a;
    data_in    = d;
    wr         = 1'b1;
    issue_flag = 1'b1;
    sb_q.push_back('{exp: hold, a: a});
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
    @(negedge clk);
    addr       = a;
    data_in    = 8'h00;
    wr         = 1'b0;
    issue_flag = 1'b1;
    sb_q.push_back('{exp: exp, a: a});
  endtask

  task automatic do_idle();
    @(negedge clk);
    addr       = 8'h00;
    data_in    = 8'h00;
    wr         = 1'b0;
    issue_flag = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    issue_flag = 1'b0;
    addr       = 8'h00;
    data_in    = 8'h00;
    wr         = 1'b0;

    // Test 1: reset for 15 ns, then reads of 0, 10, 255 return zero.
    rst = 1'b1;
    #15;
    rst = 1'b0;
    #1;
    check("reset_data_out", 8'h00, data_out, 8'h00);
    do_read(8'd0,   8'h00);
    do_read(8'd10,  8'h00);
    do_read(8'd255, 8'h00);

    // Test 2: 40 writes addr=k+10 data=k+1, then read them back.
    for (int k = 0; k < 40; k++) do_write(8'(k + 10), 8'(k + 1));
    for (int k = 0; k < 40; k++) do_read(8'(k + 10), 8'(k + 1));

    // Test 3: boundary addresses 0 and 255; neighbours stay zero.
    do_write(8'd0,   8'hA5);
    do_write(8'd255, 8'h5A);
    do_read(8'd0,   8'hA5);
    do_read(8'd1,   8'h00);
    do_read(8'd254, 8'h00);
    do_read(8'd255, 8'h5A);

    // Test 4: write holds data_out (last read gave 0x5A), next read sees new data.
    do_write_hold(8'd20, 8'h33, 8'h5A);
    do_read(8'd20, 8'h33);

    // Test 5: refill 10..49, reset between edges, everything reads zero.
    for (int k = 0; k < 40; k++) do_write(8'(k + 10), 8'(k + 1));
    do_read(8'd49, 8'd40);
    @(negedge clk);
    issue_flag = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_drop", 8'd49, data_out, 8'h00);
    #30;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) do_read(8'(k + 10), 8'h00);

    // Test 6: overwrite addr 30 and confirm neighbours keep their data.
    do_write(8'd29, 8'h11);
    do_write(8'd30, 8'h15);
    do_write(8'd31, 8'h22);
    do_read(8'd30, 8'h15);
    do_write(8'd30, 8'hFF);
    do_read(8'd30, 8'hFF);
    do_read(8'd29, 8'h11);
    do_read(8'd31, 8'h22);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) do_idle();
    do_idle();
    do_idle();
    n_checks++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
